// File: rtl/mux_arbiter_if.sv
// rtl/mux_arbiter_if.sv - requester, downstream and status signals of the 2:1 mux arbiter
interface mux_arbiter_if #(
    parameter int WIDTH = 6
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             out_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             grant_a;
    logic             grant_b;
    logic [7:0]       cnt_a;
    logic [7:0]       cnt_b;

    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready,
        output sel, out_valid, out_data, grant_a, grant_b, cnt_a, cnt_b
    );

    modport master (
        output req_a, data_a, req_b, data_b, out_ready,
        input  sel, out_valid, out_data, grant_a, grant_b, cnt_a, cnt_b
    );
endinterface

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin two-requester arbiter driving a registered shared 2:1 mux
module mux_arbiter #(
    parameter int WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_arbiter_if.slave  bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic             sel_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic [7:0]       cnt_a_q;
    logic [7:0]       cnt_b_q;
    logic             pick;
    logic             done;

    // On a tie the requester that did not win last time goes next (last=1 means B).
    always_comb begin
        pick = 1'b0;
        if (bus.req_a && bus.req_b) begin
            pick = ~last_q;
        end else if (bus.req_b) begin
            pick = 1'b1;
        end
    end

    assign done = (state == ST_BUSY) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b1;
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        sel_q   <= pick;
                        data_q  <= pick ? bus.data_b : bus.data_a;
                        valid_q <= 1'b1;
                        state   <= ST_BUSY;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= sel_q;
                        state   <= ST_IDLE;
                        if (sel_q) begin
                            cnt_b_q <= cnt_b_q + 8'd1;
                        end else begin
                            cnt_a_q <= cnt_a_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.grant_a   = done && !sel_q;
    assign bus.grant_b   = done && sel_q;
    assign bus.cnt_a     = cnt_a_q;
    assign bus.cnt_b     = cnt_b_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - scoreboard bench for mux_arbiter with a transfer-level reference model
module tb_mux_arbiter;
    localparam int W = 6;

    typedef struct packed {
        logic         owner;
        logic [W-1:0] data;
    } xfer_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   errors;

    mux_arbiter_if #(.WIDTH(W)) bus ();

    mux_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one pending transfer at a time, owner chosen by plain round-robin rules.
    xfer_t  expq[$];
    bit     m_busy;
    bit     m_owner;
    bit     m_last;
    int     m_cnt[2];
    logic [W-1:0] m_data;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_owner  = 0;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_data   = '0;
    endtask

    // Called at posedge+1: check current state, apply inputs, advance model, wait next edge.
    task automatic step(input bit ra, input logic [W-1:0] da, input bit rb,
                        input logic [W-1:0] db, input bit rdy);
        bit win;
        check("out_valid", int'(bus.out_valid), int'(m_busy));
        check("cnt_a", int'(bus.cnt_a), m_cnt[0]);
        check("cnt_b", int'(bus.cnt_b), m_cnt[1]);
        if (m_busy) begin
            check("hold_data", int'(bus.out_data), int'(m_data));
            check("hold_sel", int'(bus.sel), int'(m_owner));
        end
        bus.req_a = ra; bus.data_a = da;
        bus.req_b = rb; bus.data_b = db;
        bus.out_ready = rdy;
        if (!m_busy) begin
            if (ra || rb) begin
                if (ra && rb) win = (m_last == 1) ? 1'b0 : 1'b1;
                else          win = rb;
                m_owner = win;
                m_data  = win ? db : da;
                m_busy  = 1;
            end
        end else if (rdy) begin
            expq.push_back('{owner: m_owner, data: m_data});
            m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 256;
            m_last = m_owner;
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_a = 0; bus.req_b = 0; bus.data_a = '0; bus.data_b = '0; bus.out_ready = 0;
        model_reset();
        expq.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every observed grant must match the next scoreboard entry.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.grant_a && bus.grant_b) check("grant_excl", 1, 0);
                if (bus.grant_a || bus.grant_b) begin
                    if (expq.size() == 0) begin
                        check("unexpected_grant", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        check("grant_b", int'(bus.grant_b), int'(e.owner));
                        check("grant_sel", int'(bus.sel), int'(e.owner));
                        check("grant_data", int'(bus.out_data), int'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        tests  = 0;
        errors = 0;
        do_reset();

        check("rst_sel", int'(bus.sel), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_data", int'(bus.out_data), 0);
        check("rst_cnt_a", int'(bus.cnt_a), 0);

        // Single A transfer
        step(1, 6'h2A, 0, 6'h00, 1);
        check("single_sel", int'(bus.sel), 0);
        check("single_data", int'(bus.out_data), 'h2A);
        step(0, 6'h00, 0, 6'h00, 1);
        step(0, 6'h00, 0, 6'h00, 1);
        check("single_cnt_a", int'(bus.cnt_a), 1);

        // Tie after reset: A, B, A, B
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 6'h05, 1, 6'h3C, 1);
        step(0, 6'h00, 0, 6'h00, 1);
        check("tie_cnt_a", int'(bus.cnt_a), 2);
        check("tie_cnt_b", int'(bus.cnt_b), 2);

        // Backpressure on B while its operand changes
        step(0, 6'h00, 1, 6'h11, 0);
        for (int i = 0; i < 5; i++) step(0, 6'h00, 1, (i < 2) ? 6'h11 : 6'h22, 0);
        check("bp_data", int'(bus.out_data), 'h11);
        step(0, 6'h00, 0, 6'h22, 1);
        step(0, 6'h00, 0, 6'h00, 0);

        // Asynchronous reset while BUSY
        step(1, 6'h17, 0, 6'h00, 0);
        step(0, 6'h17, 0, 6'h00, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(bus.out_valid), 0);
        check("arst_data", int'(bus.out_data), 0);
        check("arst_sel", int'(bus.sel), 0);
        check("arst_cnt_b", int'(bus.cnt_b), 0);
        model_reset();
        bus.req_a = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                 W'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) step(0, 6'h00, 0, 6'h00, 1);

        // Counter wrap: 256 back-to-back A transfers
        do_reset();
        for (int i = 0; i < 512; i++) step(1, W'(i), 0, 6'h00, 1);
        step(0, 6'h00, 0, 6'h00, 1);
        check("wrap_cnt_a", int'(bus.cnt_a), 0);
        check("wrap_cnt_b", int'(bus.cnt_b), 0);

        check("scoreboard_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
